// File: rtl/hub75_scan_ctrl.sv
`timescale 1ns/1ps
// HUB75 scan controller: shifts one row of the displayed frame buffer per bit
// plane, latches it, then lights it for a binary-weighted time (BCM).
module hub75_scan_ctrl #(
    parameter int COLS       = 64,
    parameter int ROW_BITS   = 5,
    parameter int PLANES     = 4,
    parameter int BASE_TIME  = 16,
    localparam int COL_BITS   = $clog2(COLS),
    localparam int ADDR_WIDTH = 1 + ROW_BITS + COL_BITS,
    localparam int DATA_WIDTH = 6 * PLANES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  disp_buf,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [5:0]            rgb,
    output logic                  sclk,
    output logic                  lat,
    output logic                  oe_n,
    output logic [ROW_BITS-1:0]   row_addr,
    output logic                  frame_done
);
    localparam int PLANE_BITS = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int CNT_W      = $clog2(BASE_TIME) + PLANES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CLK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t                state, state_nxt;
    logic [COL_BITS-1:0]   col;
    logic [ROW_BITS-1:0]   row;
    logic [PLANE_BITS-1:0] plane;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      disp_len;
    logic [5:0]            plane_bits;
    logic                  last_col, last_plane, last_row;
    logic                  disp_end, frame_end;

    assign last_col   = (col == COL_BITS'(COLS - 1));
    assign last_plane = (plane == PLANE_BITS'(PLANES - 1));
    assign last_row   = &row;
    assign disp_end   = (state == S_DISPLAY) && (cnt == '0);
    assign frame_end  = disp_end && last_plane && last_row;

    // Plane k is lit for BASE_TIME << k cycles; CNT_W holds the largest weight.
    assign disp_len = CNT_W'(BASE_TIME) << plane;

    // Pick bit [plane] out of each of the six P-bit colour fields.
    for (genvar c = 0; c < 6; c++) begin : g_chan
        logic [PLANES-1:0] chan;
        assign chan          = ram_dout[c*PLANES +: PLANES];
        assign plane_bits[c] = chan[plane];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (enable) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_WAIT;
            S_WAIT:    state_nxt = S_CLK;
            S_CLK:     state_nxt = last_col ? S_LATCH : S_FETCH;
            S_LATCH:   state_nxt = S_DISPLAY;
            S_DISPLAY: begin
                // enable only matters at the frame boundary; mid-frame drops finish the frame
                if (disp_end) state_nxt = (frame_end && !enable) ? S_IDLE : S_FETCH;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ram_en = 1'b0;
        sclk   = 1'b0;
        lat    = 1'b0;
        oe_n   = 1'b1;
        case (state)
            S_FETCH:   ram_en = 1'b1;
            S_CLK:     sclk   = 1'b1;
            S_LATCH:   lat    = 1'b1;
            S_DISPLAY: oe_n   = 1'b0;
            default:   ;
        endcase
    end

    assign frame_done = frame_end;
    assign swap_ack   = frame_end & swap_req;
    assign ram_addr   = {disp_buf, row, col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            plane    <= '0;
            cnt      <= '0;
            rgb      <= '0;
            row_addr <= '0;
            disp_buf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    col   <= '0;
                    row   <= '0;
                    plane <= '0;
                end
                S_WAIT: rgb <= plane_bits;
                S_CLK: begin
                    if (last_col) begin
                        col      <= '0;
                        // row_addr moves together with lat, never while a row is lit
                        row_addr <= row;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                S_LATCH: cnt <= disp_len - 1'b1;
                S_DISPLAY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (last_plane) begin
                            plane <= '0;
                            row   <= row + 1'b1;
                        end else begin
                            plane <= plane + 1'b1;
                        end
                        if (frame_end && swap_req) disp_buf <= ~disp_buf;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
